serial_par_rx: RTL and testbench

//  Receive-side serial-to-parallel converter with comma alignment; sits directly upstream of the L2 demux in phy_rx.

---
 rtl/serial_par_rx_pkg.sv | 15 +
 rtl/serial_par_rx_comma_align_fsm.sv | 88 ++++++++
 rtl/serial_par_rx.sv | 69 ++++++
 tb/tb_serial_par_rx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_par_rx_pkg.sv
// Shared phy receive/transmit definitions: alignment state encoding and
// default symbol parameters (also consumed by the tx serialiser).
package serial_par_rx_pkg;

    localparam int unsigned WIDTH_DEF       = 8;
    localparam logic [7:0]  COMMA_DEF       = 8'hBC;
    localparam int unsigned COMMA_COUNT_DEF = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOCK   = 2'd1,
        ACTIVE = 2'd2
    } align_state_e;

endpackage : serial_par_rx_pkg

// File: rtl/serial_par_rx_comma_align_fsm.sv
// Comma alignment FSM: finds symbol alignment on the comma, counts
// consecutive aligned commas, and tracks the symbol bit position.
// Ports:
//   clk_32f      in   bit clock
//   reset_L      in   async active-low reset
//   comma_hit_c  in   current WIDTH-bit window equals COMMA
//   boundary_c   out  window holds a complete aligned symbol (LOCK/ACTIVE)
//   active       out  registered: link aligned (state is ACTIVE)
module comma_align_fsm
    import serial_par_rx_pkg::*;
#(
    parameter int unsigned WIDTH       = WIDTH_DEF,
    parameter int unsigned COMMA_COUNT = COMMA_COUNT_DEF
) (
    input  logic clk_32f,
    input  logic reset_L,
    input  logic comma_hit_c,
    output logic boundary_c,
    output logic active
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned CC_W  = $clog2(COMMA_COUNT + 1);

    align_state_e     state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CC_W-1:0]  comma_cnt_q, comma_cnt_d;

    // State, counters and the active flag
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= SEARCH;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            active      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            active      <= (state_d == ACTIVE);
        end
    end

    // Next-state logic; bit_cnt only advances once an alignment candidate exists
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        comma_cnt_d = comma_cnt_q;
        boundary_c  = (state_q != SEARCH) && (bit_cnt_q == CNT_W'(WIDTH - 1));

        unique case (state_q)
            SEARCH: begin
                bit_cnt_d = '0;
                if (comma_hit_c) begin
                    comma_cnt_d = CC_W'(1);
                    state_d     = (COMMA_COUNT == 1) ? ACTIVE : LOCK;
                end
            end
            LOCK: begin
                bit_cnt_d = boundary_c ? '0 : bit_cnt_q + CNT_W'(1);
                if (boundary_c) begin
                    if (comma_hit_c) begin
                        if (comma_cnt_q >= CC_W'(COMMA_COUNT - 1)) begin
                            comma_cnt_d = CC_W'(COMMA_COUNT);
                            state_d     = ACTIVE;
                        end else begin
                            comma_cnt_d = comma_cnt_q + CC_W'(1);
                        end
                    end else begin
                        // Misaligned or lost comma: slide again from scratch
                        comma_cnt_d = '0;
                        bit_cnt_d   = '0;
                        state_d     = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                bit_cnt_d = boundary_c ? '0 : bit_cnt_q + CNT_W'(1);
            end
            default: begin
                state_d     = SEARCH;
                bit_cnt_d   = '0;
                comma_cnt_d = '0;
            end
        endcase
    end

endmodule : comma_align_fsm

// File: rtl/serial_par_rx.sv
// Serial-to-parallel receiver with comma alignment, upstream of the L2 demux.
// Ports:
//   clk_32f    in   bit clock, one serial bit per rising edge
//   reset_L    in   async active-low reset
//   data_in    in   serial stream, MSB of each symbol first
//   data_000   out  last received non-comma symbol, held between updates
//   valid_000  out  data_000 is a data symbol for the current symbol period
//   byte_stb   out  one-cycle pulse per symbol boundary while active
//   active     out  link aligned and synchronised
module serial_par_rx
    import serial_par_rx_pkg::*;
#(
    parameter int unsigned      WIDTH       = WIDTH_DEF,
    parameter logic [WIDTH-1:0] COMMA       = WIDTH'(COMMA_DEF),
    parameter int unsigned      COMMA_COUNT = COMMA_COUNT_DEF
) (
    input  logic             clk_32f,
    input  logic             reset_L,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_000,
    output logic             valid_000,
    output logic             byte_stb,
    output logic             active
);

    logic [WIDTH-2:0] sr_q;
    logic [WIDTH-1:0] window_c;
    logic             comma_hit_c;
    logic             boundary_c;
    logic             sym_done_c;

    // Most recent WIDTH bits including the bit being sampled this edge
    assign window_c    = {sr_q, data_in};
    assign comma_hit_c = (window_c == COMMA);
    assign sym_done_c  = boundary_c && active;

    comma_align_fsm #(
        .WIDTH       (WIDTH),
        .COMMA_COUNT (COMMA_COUNT)
    ) u_fsm (
        .clk_32f     (clk_32f),
        .reset_L     (reset_L),
        .comma_hit_c (comma_hit_c),
        .boundary_c  (boundary_c),
        .active      (active)
    );

    // Shift register and symbol output registers
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            sr_q      <= '0;
            data_000  <= '0;
            valid_000 <= 1'b0;
            byte_stb  <= 1'b0;
        end else begin
            sr_q     <= window_c[WIDTH-2:0];
            byte_stb <= sym_done_c;
            if (sym_done_c) begin
                if (comma_hit_c) begin
                    valid_000 <= 1'b0;
                end else begin
                    data_000  <= window_c;
                    valid_000 <= 1'b1;
                end
            end
        end
    end

endmodule : serial_par_rx

// File: tb/tb_serial_par_rx.sv
module tb_serial_par_rx;

    logic       clk_32f;
    logic       reset_L;
    logic       data_in;
    logic [7:0] data_000;
    logic       valid_000;
    logic       byte_stb;
    logic       active;

    int total;
    int bad;
    int stb_seen;

    serial_par_rx dut (
        .clk_32f   (clk_32f),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .data_000  (data_000),
        .valid_000 (valid_000),
        .byte_stb  (byte_stb),
        .active    (active)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    // Drive one bit (1 time unit after an edge), then sample just after the next edge
    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
        if (byte_stb === 1'b1) stb_seen++;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic apply_reset();
        reset_L = 1'b0;
        @(posedge clk_32f);
        #1;
        reset_L = 1'b1;
    endtask

    task automatic send_commas(input int n);
        for (int i = 0; i < n; i++) send_byte(8'hBC);
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_in = i[0];
            @(posedge clk_32f);
            #1;
            total++;
            if ({data_000, valid_000, byte_stb, active} !== 11'd0) begin
                bad++;
                $display("FAIL reset_cycle%0d: got data=%h valid=%b stb=%b active=%b want all 0",
                         i, data_000, valid_000, byte_stb, active);
            end
        end
        reset_L = 1'b1;
    endtask

    task automatic test_aligned();
        apply_reset();
        send_commas(3);
        total++;
        if (active !== 1'b0) begin
            bad++;
            $display("FAIL aligned_3commas: active=%b want 0", active);
        end
        send_byte(8'hBC);
        total++;
        if (active !== 1'b1 || valid_000 !== 1'b0) begin
            bad++;
            $display("FAIL aligned_4commas: active=%b valid=%b want 1 0", active, valid_000);
        end
        // First 7 bits of 0x55: outputs not yet updated
        stb_seen = 0;
        for (int i = 7; i >= 1; i--) send_bit(1'(8'h55 >> i));
        total++;
        if (data_000 !== 8'h00 || valid_000 !== 1'b0 || stb_seen != 0) begin
            bad++;
            $display("FAIL aligned_pre55: data=%h valid=%b stbs=%0d want 00 0 0",
                     data_000, valid_000, stb_seen);
        end
        send_bit(1'b1);
        total++;
        if (data_000 !== 8'h55 || valid_000 !== 1'b1 || byte_stb !== 1'b1) begin
            bad++;
            $display("FAIL aligned_55: data=%h valid=%b stb=%b want 55 1 1",
                     data_000, valid_000, byte_stb);
        end
        stb_seen = 0;
        send_byte(8'hA3);
        total++;
        if (data_000 !== 8'hA3 || valid_000 !== 1'b1 || stb_seen != 1) begin
            bad++;
            $display("FAIL aligned_A3: data=%h valid=%b stbs=%0d want A3 1 1",
                     data_000, valid_000, stb_seen);
        end
    endtask

    task automatic test_slide();
        apply_reset();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_commas(4);
        total++;
        if (active !== 1'b1) begin
            bad++;
            $display("FAIL slide_active: active=%b want 1", active);
        end
        send_byte(8'h3C);
        total++;
        if (data_000 !== 8'h3C || valid_000 !== 1'b1) begin
            bad++;
            $display("FAIL slide_3C: data=%h valid=%b want 3C 1", data_000, valid_000);
        end
    endtask

    task automatic test_lose_lock();
        apply_reset();
        send_commas(3);
        send_byte(8'h12);
        total++;
        if (active !== 1'b0 || valid_000 !== 1'b0) begin
            bad++;
            $display("FAIL lose_lock: active=%b valid=%b want 0 0", active, valid_000);
        end
        send_commas(3);
        total++;
        if (active !== 1'b0) begin
            bad++;
            $display("FAIL relock_3: active=%b want 0", active);
        end
        send_byte(8'hBC);
        total++;
        if (active !== 1'b1) begin
            bad++;
            $display("FAIL relock_4: active=%b want 1", active);
        end
    endtask

    task automatic test_data_idle_data();
        logic [7:0] seq [3];
        logic [7:0] exp_d [3];
        logic       exp_v [3];
        seq   = '{8'h77, 8'hBC, 8'h66};
        exp_d = '{8'h77, 8'h77, 8'h66};
        exp_v = '{1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            stb_seen = 0;
            send_byte(seq[k]);
            total++;
            if (data_000 !== exp_d[k] || valid_000 !== exp_v[k] || byte_stb !== 1'b1 || stb_seen != 1) begin
                bad++;
                $display("FAIL stream_sym%0d: data=%h valid=%b stb=%b stbs=%0d want %h %b 1 1",
                         k, data_000, valid_000, byte_stb, stb_seen, exp_d[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_midbyte_reset();
        for (int i = 7; i >= 4; i--) send_bit(1'(8'hC3 >> i));
        reset_L = 1'b0;
        #1;
        total++;
        if ({data_000, valid_000, byte_stb, active} !== 11'd0) begin
            bad++;
            $display("FAIL midreset_async: data=%h valid=%b stb=%b active=%b want all 0",
                     data_000, valid_000, byte_stb, active);
        end
        @(posedge clk_32f);
        #1;
        reset_L = 1'b1;
        send_commas(3);
        total++;
        if (active !== 1'b0) begin
            bad++;
            $display("FAIL midreset_3commas: active=%b want 0", active);
        end
        send_byte(8'hBC);
        send_byte(8'h5A);
        total++;
        if (active !== 1'b1 || data_000 !== 8'h5A || valid_000 !== 1'b1) begin
            bad++;
            $display("FAIL midreset_relock: active=%b data=%h valid=%b want 1 5A 1",
                     active, data_000, valid_000);
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        stb_seen = 0;
        reset_L  = 1'b0;
        data_in  = 1'b0;
        test_reset();
        test_aligned();
        test_slide();
        test_lose_lock();
        test_data_idle_data();
        test_midbyte_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_par_rx
